// File: rtl/zero_flag_pkg.sv
// zero_flag_pkg: shared ALU constants for the status-flag logic
// ALU_WIDTH     default datapath width
// ZERO_FLAG_IDX position of the zero bit in the ALU status word (N,Z,C,V)
package zero_flag_pkg;
  localparam int ALU_WIDTH = 4;
  localparam int ZERO_FLAG_IDX = 2;
endpackage

// File: rtl/zero_flag_if.sv
// zero_flag_if: result word in, zero flags out
// master drives number/valid/clr_sticky and samples zero/zero_q/zero_seen; slave is the flag block
interface zero_flag_if import zero_flag_pkg::*; #(parameter int WIDTH = ALU_WIDTH);
  logic [WIDTH-1:0] number;
  logic valid;
  logic clr_sticky;
  logic zero;
  logic zero_q;
  logic zero_seen;
  modport master(output number, valid, clr_sticky, input zero, zero_q, zero_seen);
  modport slave(input number, valid, clr_sticky, output zero, zero_q, zero_seen);
endinterface

// File: rtl/zero_flag_or_reduce.sv
// zero_flag_or_reduce: balanced OR tree over a WIDTH-bit word
// a: input word, y: OR of all bits
module zero_flag_or_reduce #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] a,
  output logic             y
);
  if (WIDTH == 1) begin : g_leaf
    assign y = a[0];
  end else begin : g_node
    localparam int L = WIDTH / 2;
    logic lo, hi;
    zero_flag_or_reduce #(.WIDTH(L)) u_lo (.a(a[L-1:0]), .y(lo));
    zero_flag_or_reduce #(.WIDTH(WIDTH - L)) u_hi (.a(a[WIDTH-1:L]), .y(hi));
    assign y = lo | hi;
  end
endmodule

// File: rtl/zero_flag.sv
// zero_flag: active-low zero flag with registered copy and sticky zero-seen
// clk, rst_n (sync, active-low); bus: number/valid/clr_sticky in, zero/zero_q/zero_seen out
module zero_flag import zero_flag_pkg::*; #(parameter int WIDTH = ALU_WIDTH) (
  input logic        clk,
  input logic        rst_n,
  zero_flag_if.slave bus
);
  logic z, zero_q, zero_seen;
  zero_flag_or_reduce #(.WIDTH(WIDTH)) u_or (.a(bus.number), .y(z));
  // a valid zero in the clearing cycle sets rather than clears
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q <= 1'b1;
      zero_seen <= 1'b0;
    end else begin
      if (bus.valid) zero_q <= z;
      zero_seen <= (bus.valid && !z) ? 1'b1 : bus.clr_sticky ? 1'b0 : zero_seen;
    end
  end
  assign bus.zero = z;
  assign bus.zero_q = zero_q;
  assign bus.zero_seen = zero_seen;
endmodule

// File: tb/tb_zero_flag.sv
// tb_zero_flag: directed table-driven check of zero_flag at WIDTH 4, 1 and 32
module tb_zero_flag;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  zero_flag_if #(.WIDTH(4)) b4();
  zero_flag_if #(.WIDTH(1)) b1();
  zero_flag_if #(.WIDTH(32)) b32();
  zero_flag #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b4));
  zero_flag #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  zero_flag #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  typedef struct {
    logic [3:0] number;
    logic       zero;
  } comb_vec_t;
  typedef struct {
    logic       rst_n;
    logic       valid;
    logic       clr;
    logic [3:0] number;
    logic       zero;
    logic       zero_q;
    logic       zero_seen;
  } seq_vec_t;
  comb_vec_t cv[10];
  seq_vec_t sv[17];
  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask
  initial begin
    cv = '{'{4'd10, 1'b1}, '{4'd0, 1'b0}, '{4'd1, 1'b1}, '{4'd2, 1'b1}, '{4'd9, 1'b1},
           '{4'd0, 1'b0}, '{4'd1, 1'b1}, '{4'd2, 1'b1}, '{4'd4, 1'b1}, '{4'd8, 1'b1}};
    sv = '{
      '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 4'd7, 1'b1, 1'b1, 1'b1},
      '{1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd8, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1}};
    b4.valid = 1'b0;
    b4.clr_sticky = 1'b0;
    b4.number = 4'd0;
    b1.valid = 1'b0;
    b1.clr_sticky = 1'b0;
    b1.number = 1'b0;
    b32.valid = 1'b0;
    b32.clr_sticky = 1'b0;
    b32.number = 32'd0;
    for (int i = 0; i < 10; i++) begin
      b4.number = cv[i].number;
      #10;
      chk($sformatf("comb[%0d] number=%0d", i, cv[i].number), b4.zero, cv[i].zero);
    end
    for (int i = 0; i < 16; i++) begin
      b4.number = 4'(i);
      #10;
      chk($sformatf("exhaustive number=%0d", i), b4.zero, i != 0);
    end
    b1.number = 1'b0;
    b32.number = 32'd0;
    #10;
    chk("w1 zero word", b1.zero, 1'b0);
    chk("w32 zero word", b32.zero, 1'b0);
    b1.number = 1'b1;
    b32.number = 32'h8000_0000;
    #10;
    chk("w1 msb", b1.zero, 1'b1);
    chk("w32 msb", b32.zero, 1'b1);
    b32.number = 32'h0000_0001;
    #10;
    chk("w32 lsb", b32.zero, 1'b1);
    b32.number = 32'h0001_0000;
    #10;
    chk("w32 mid", b32.zero, 1'b1);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rst_n = sv[i].rst_n;
      b4.valid = sv[i].valid;
      b4.clr_sticky = sv[i].clr;
      b4.number = sv[i].number;
      @(posedge clk);
      #1;
      chk($sformatf("seq[%0d] zero", i), b4.zero, sv[i].zero);
      chk($sformatf("seq[%0d] zero_q", i), b4.zero_q, sv[i].zero_q);
      chk($sformatf("seq[%0d] zero_seen", i), b4.zero_seen, sv[i].zero_seen);
    end
    @(negedge clk);
    rst_n = 1'b1;
    b4.valid = 1'b1;
    b4.number = 4'd0;
    b4.clr_sticky = 1'b0;
    #2;
    chk("zero_q latency before edge", b4.zero_q, 1'b0);
    b4.number = 4'd6;
    @(posedge clk);
    #1;
    chk("zero_q after edge", b4.zero_q, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/zero_flag.md
Name: zero_flag

Overview:
- ALU status-flag block. Evaluates a WIDTH-bit result word and drives an active-low zero indication: 0 when the word is all zeros, 1 otherwise.
- Sits beside the ALU datapath. The combinational output feeds same-cycle consumers.
- A registered copy and a sticky "zero seen" flag feed the status register and branch logic.

Parameters:
- WIDTH, 4, bit width of the evaluated word; any integer >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- number  input  WIDTH  word under test (ALU result).
- zero  output  1  combinational flag, active-low: 0 iff number == 0, else 1.
- valid  input  1  qualifies number for the registered and sticky outputs.
- zero_q  output  1  registered copy of zero, captured when valid = 1.
- clr_sticky  input  1  clears the sticky flag.
- zero_seen  output  1  sticky flag: 1 once any valid zero word has been seen since the last reset or clear.

Behaviour:
- zero is purely combinational: zero = OR-reduction of all bits of number.
  - number = 0 gives zero = 0.
  - Any set bit, including only the MSB or only the LSB, gives zero = 1.
  - Settles within the same delta cycle as number; no clock or reset dependency.
  - An X/Z bit on number propagates X on zero in simulation; no masking.
- Reset: on a rising clk edge with rst_n = 0, zero_q <= 1 and zero_seen <= 0.
  - Reset takes priority over valid and clr_sticky.
  - zero is unaffected by reset.
- zero_q:
  - On a rising edge with rst_n = 1 and valid = 1, zero_q <= zero (current number).
  - With valid = 0 it holds its value.
  - One-cycle latency from number to zero_q.
- zero_seen, on a rising edge with rst_n = 1:
  - clr_sticky = 1 and valid = 1 with number == 0: zero_seen <= 1. Set wins over clear, so a zero in the clearing cycle is not lost.
  - clr_sticky = 1 otherwise: zero_seen <= 0.
  - valid = 1 and number == 0: zero_seen <= 1.
  - Otherwise: hold.
- Reset mid-operation: the next edge forces the reset values regardless of inputs. Normal updates resume on the first edge with rst_n = 1.
- Width rules:
  - No arithmetic is performed and no truncation occurs.
  - WIDTH = 1 degenerates to zero = number[0].

Decomposition:
- Shared ALU package holds the ALU_WIDTH constant (default 4), used to set WIDTH at instantiation.
- Package also holds a flag-index constant for the zero bit's position in the status word.
- One natural sub-module: or_reduce.
  - Parameterized WIDTH, balanced OR tree, single output.
  - Instantiated once to produce zero.
- Registers live in zero_flag itself.

Test Plan:
- Combinational sweep, WIDTH = 4, number = 10, 0, 1, 2, 9, 0, checking after 10 time units each -> zero = 1, 0, 1, 1, 1, 0.
- Exhaustive 0..15 -> zero = 0 only at 0; single-bit patterns 1, 2, 4, 8 -> zero = 1.
- Reset: rst_n = 0 for one edge with valid = 1, number = 0, clr_sticky = 0 -> zero_q = 1, zero_seen = 0 after the edge; zero = 0 throughout.
- Registered path, rst_n = 1: valid = 1 with number = 0 then 5 on consecutive edges -> zero_q = 0, then 1, each one cycle late. Then valid = 0 with number = 0 -> zero_q holds 1.
- Sticky:
  - valid = 1, number = 3 -> zero_seen = 0.
  - Next edge number = 0 -> zero_seen = 1.
  - Next edge number = 7 -> zero_seen stays 1.
  - clr_sticky = 1 with number = 7 -> zero_seen = 0.
  - clr_sticky = 1 with valid = 1, number = 0 -> zero_seen = 1.
- Parameter check, WIDTH = 1 and WIDTH = 32: number = 0 -> zero = 0; number = MSB only (32'h8000_0000) -> zero = 1.
